priority_encoder_16x4: RTL and testbench
========================================

Name: priority_encoder_16x4

Overview:
- Sequential 16-to-4 encoder; the inverse of the team's 4x16 one-hot decoder.
- Captures request pulses on 16 lines into a pending register.
- Emits the index of the highest-priority pending line as a 4-bit code, using a valid/ready handshake.
- Clears each line once it has been served.
- Sits between interrupt/event sources and a consumer that may stall.

Parameters:
- N, 16, number of request lines.
- W, 4, code width; must satisfy 2**W == N.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  N  request pulses; a bit high for one or more cycles marks that line pending.
- out  output  W  encoded index of the served line; valid only while out_valid=1.
- out_valid  output  1  out holds a code not yet accepted.
- out_ready  input  1  consumer accepts out when out_valid && out_ready at a rising edge.
- pending  output  N  current pending register, for debug/status.
- dropped  output  1  one-cycle pulse: a request arrived on a line already pending.

Behaviour:
- Reset (rst_n=0, asynchronous): pending=0, out=0, out_valid=0, dropped=0. Reset mid-transfer discards the held code and all pending bits; nothing is replayed afterwards.
- Output slot has two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- slot_free = !out_valid || out_ready.
- Selection:
  - sel = index of the highest set bit of the registered pending; bit N-1 has highest priority.
  - Selection uses pending only, never live in.
- Load rule at each edge:
  - If slot_free and pending!=0: out<=sel, out_valid<=1, pending[sel] cleared.
  - Else if out_valid && out_ready: out_valid<=0; out holds its last value.
  - Else: out and out_valid hold.
- Capture rule at each edge: pending_next = (pending & ~clear_mask) | in. clear_mask is the one-hot of sel when a load occurs, else 0.
- Set wins over clear: if in[sel]=1 in the same cycle sel is loaded, the bit stays pending and the line is served again later.
- dropped <= |(in & pending & ~clear_mask). It is registered, high for exactly one cycle per offending edge.
- Latency:
  - A request sampled at edge k sets pending after edge k.
  - With the slot free, out_valid=1 with its code after edge k+1 (2 edges from input to code).
- Throughput: one code per cycle when out_ready is held high and pending is non-empty (back-to-back, no bubble).
- Stall: while out_valid=1 && out_ready=0, out and out_valid are stable. New requests still accumulate in pending.
- Empty: pending=0 and slot free gives out_valid=0 after that edge. No spurious codes.
- Wrap-around: none. Priority is fixed, and a continuously asserted high line starves lower lines; this starvation is intended.
- in held high for several cycles counts as one request per edge. The repeats raise dropped while the line is pending, until it is served.

Test Plan:
- Reset with in=16'h0000, out_ready=1 -> out_valid=0, pending=0, out=0, dropped=0. Assert rst_n=0 mid-transfer -> all outputs reset immediately, without waiting for a clock edge.
- Single pulse in=16'h0020 for one cycle, out_ready=1 -> out_valid=1, out=4'd5 two edges after the pulse; pending=0 afterwards; out_valid=0 on the next cycle.
- Pulse in=16'h8421 once, out_ready=1 -> codes 15, 10, 5, 0 on consecutive cycles, then out_valid=0.
- Pulse in=16'h0003, out_ready=0 for 5 cycles -> out=4'd1 held stable with out_valid=1 and pending=16'h0001; raise out_ready -> 1 then 0 accepted on consecutive edges.
- Stall on code 3 with out_ready=0, then pulse in=16'h0008 again -> dropped=1 for one cycle only if bit 3 is pending. Also pulse in[7] while 7 is being loaded -> 7 is emitted twice.
- Sweep all 16 single one-hot pulses (16'h0001..16'h8000) -> out equals the bit index each time. Feeding out into the 4x16 decoder reproduces the original one-hot vector.

Source files
------------

// File: rtl/priority_encoder_16x4.sv
// Sequential 16-to-4 priority encoder: request pulses accumulate in a pending
// register and the highest pending index is handed out over a valid/ready slot.
module priority_encoder_16x4 #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    output logic [W-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         dropped
);

    // Handshake: a code transfers on a rising edge where out_valid && out_ready;
    // once out_valid is high, out and out_valid hold until that transfer happens.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t  slot;
    logic [W-1:0] sel;
    logic         slot_free;
    logic         load;
    logic [N-1:0] clear_mask;

    // Ascending scan so the last hit, the highest set bit, wins.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i]) begin
                sel = W'(i);
            end
        end
    end

    assign slot_free  = (slot == EMPTY) || out_ready;
    assign load       = slot_free && (pending != '0);
    assign clear_mask = load ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
    assign out_valid  = (slot == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot    <= EMPTY;
            out     <= '0;
            pending <= '0;
            dropped <= 1'b0;
        end else begin
            // OR-ing in after the clear lets a same-cycle request re-arm the served line.
            pending <= (pending & ~clear_mask) | in;
            dropped <= |(in & pending & ~clear_mask);
            if (load) begin
                out  <= sel;
                slot <= FULL;
            end else if ((slot == FULL) && out_ready) begin
                slot <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_priority_encoder_16x4.sv
// Directed bench for priority_encoder_16x4: each task drives a scenario and
// compares outputs against hand-computed values.
module tb_priority_encoder_16x4;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic [3:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] pending;
    logic        dropped;

    int checks;
    int failures;

    priority_encoder_16x4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs driven 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in = 16'h0000;
        out_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (out_valid !== 1'b0 || pending !== 16'h0000 || out !== 4'd0 || dropped !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: valid=%b pending=%h out=%0d dropped=%b, required 0/0000/0/0",
                     out_valid, pending, out, dropped);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || pending !== 16'h0000) begin
            failures++;
            $display("FAIL reset_idle: valid=%b pending=%h, required 0/0000", out_valid, pending);
        end
    endtask

    task automatic test_single_pulse();
        out_ready = 1'b1;
        in = 16'h0020;
        step();
        in = 16'h0000;
        checks++;
        if (pending !== 16'h0020 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_capture: pending=%h valid=%b, required 0020/0", pending, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out !== 4'd5 || pending !== 16'h0000) begin
            failures++;
            $display("FAIL single_code: valid=%b out=%0d pending=%h, required 1/5/0000",
                     out_valid, out, pending);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_empty: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_codes [4];
        exp_codes = '{4'd15, 4'd10, 4'd5, 4'd0};
        out_ready = 1'b1;
        in = 16'h8421;
        step();
        in = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out !== exp_codes[i]) begin
                failures++;
                $display("FAIL b2b_code%0d: valid=%b out=%0d, required 1/%0d",
                         i, out_valid, out, exp_codes[i]);
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || pending !== 16'h0000) begin
            failures++;
            $display("FAIL b2b_drain: valid=%b pending=%h, required 0/0000", out_valid, pending);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in = 16'h0003;
        step();
        in = 16'h0000;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out !== 4'd1 || pending !== 16'h0001) begin
                failures++;
                $display("FAIL stall_hold%0d: valid=%b out=%0d pending=%h, required 1/1/0001",
                         i, out_valid, out, pending);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out !== 4'd0 || pending !== 16'h0000) begin
            failures++;
            $display("FAIL stall_release: valid=%b out=%0d pending=%h, required 1/0/0000",
                     out_valid, out, pending);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_drain: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_dropped();
        out_ready = 1'b0;
        in = 16'h0008;
        step();
        in = 16'h0000;
        step();
        // Bit 3 was cleared by the load, so this repeat is a fresh request.
        in = 16'h0008;
        step();
        checks++;
        if (dropped !== 1'b0 || pending !== 16'h0008 || out !== 4'd3 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL drop_fresh: dropped=%b pending=%h out=%0d valid=%b, required 0/0008/3/1",
                     dropped, pending, out, out_valid);
        end
        step();
        checks++;
        if (dropped !== 1'b1 || pending !== 16'h0008) begin
            failures++;
            $display("FAIL drop_pulse: dropped=%b pending=%h, required 1/0008", dropped, pending);
        end
        in = 16'h0000;
        step();
        checks++;
        if (dropped !== 1'b0) begin
            failures++;
            $display("FAIL drop_one_cycle: dropped=%b, required 0", dropped);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out !== 4'd3 || pending !== 16'h0000) begin
            failures++;
            $display("FAIL drop_reserve: valid=%b out=%0d pending=%h, required 1/3/0000",
                     out_valid, out, pending);
        end
        step();
        // Set wins over clear: line 7 re-requested on the edge it is loaded.
        in = 16'h0080;
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || out !== 4'd7 || pending !== 16'h0080 || dropped !== 1'b0) begin
            failures++;
            $display("FAIL set_wins_first: valid=%b out=%0d pending=%h dropped=%b, required 1/7/0080/0",
                     out_valid, out, pending, dropped);
        end
        in = 16'h0000;
        step();
        checks++;
        if (out_valid !== 1'b1 || out !== 4'd7 || pending !== 16'h0000) begin
            failures++;
            $display("FAIL set_wins_second: valid=%b out=%0d pending=%h, required 1/7/0000",
                     out_valid, out, pending);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL set_wins_drain: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] vec;
        logic [15:0] decoded;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vec = 16'h0001 << i;
            in = vec;
            step();
            in = 16'h0000;
            step();
            decoded = 16'h0001 << out;
            checks++;
            if (out_valid !== 1'b1 || out !== 4'(i) || decoded !== vec) begin
                failures++;
                $display("FAIL sweep_bit%0d: valid=%b out=%0d decoded=%h, required 1/%0d/%h",
                         i, out_valid, out, decoded, i, vec);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in = 16'h0003;
        step();
        in = 16'h0000;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || pending !== 16'h0000 || out !== 4'd0 || dropped !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: valid=%b pending=%h out=%0d dropped=%b, required 0/0000/0/0",
                     out_valid, pending, out, dropped);
        end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || pending !== 16'h0000) begin
            failures++;
            $display("FAIL no_replay: valid=%b pending=%h, required 0/0000", out_valid, pending);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_pulse();
        test_back_to_back();
        test_stall();
        test_dropped();
        test_sweep();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
